multu_hilo: RTL and testbench

Sequential unsigned 32x32 multiplier with the architectural Hi/Lo register pair.
- Sits directly upstream of the ALU output mux and drives its HiOut/LoOut inputs; MFHI/MFLO read results through the mux.
- Starts when the function code on Signal equals MULTU (6'b011001, decimal 25).
- Computes the 64-bit product by shift-and-add over 32 cycles, then commits it to Hi/Lo.
- Hi/Lo hold their value between MULTU operations.

---
 rtl/multu_hilo_if.sv | 26 ++
 rtl/multu_hilo.sv | 84 ++++++++
 tb/tb_multu_hilo.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/multu_hilo_if.sv
// multu_hilo_if: operand/function-code bus into the Hi/Lo multiplier and its result outputs.
// Ports: dataA/dataB multiplicand/multiplier, Signal function code (shared with the ALU output mux),
//        HiOut/LoOut architectural Hi/Lo, busy while multiplying, done one-cycle commit pulse.
interface multu_hilo_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [5:0]       Signal;
  logic [WIDTH-1:0] HiOut;
  logic [WIDTH-1:0] LoOut;
  logic             busy;
  logic             done;

  // Decoder/ALU side: supplies operands and function code, reads Hi/Lo.
  modport master (
    output dataA, dataB, Signal,
    input  HiOut, LoOut, busy, done
  );

  // Multiplier side.
  modport slave (
    input  dataA, dataB, Signal,
    output HiOut, LoOut, busy, done
  );
endinterface

// File: rtl/multu_hilo.sv
// multu_hilo: sequential unsigned WIDTHxWIDTH shift-and-add multiplier owning the Hi/Lo pair.
// Ports: clk rising-edge clock, reset async active-low, bus (slave) carries operands, Signal,
//        HiOut/LoOut, busy and done. Result lands WIDTH edges after the start edge; starts while busy are dropped.
module multu_hilo #(
  parameter int         WIDTH      = 32,
  parameter logic [5:0] MULTU_CODE = 6'b011001
) (
  input  logic       clk,
  input  logic       reset,
  multu_hilo_if.slave bus
);

  // One extra bit so the counter can represent WIDTH without wrapping.
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  // One multiply step: conditionally add the multiplicand into the upper half,
  // keep the carry as the new top bit and shift the whole product right by one.
  logic [WIDTH:0]     sum_d;
  logic [2*WIDTH-1:0] prod_d;

  always_comb begin
    sum_d  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d = {sum_d, prod_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.Signal == MULTU_CODE) begin
            mcand_q <= bus.dataA;
            prod_q  <= {{WIDTH{1'b0}}, bus.dataB};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= MUL;
          end
        end
        MUL: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + 1'b1;
          // Last step: commit the product including this step's addition.
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            hi_q    <= prod_d[2*WIDTH-1:WIDTH];
            lo_q    <= prod_d[WIDTH-1:0];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.HiOut = hi_q;
  assign bus.LoOut = lo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_multu_hilo.sv
module tb_multu_hilo;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] ADD   = 6'b100000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  // Reference Hi/Lo: what the architectural registers should hold right now.
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  multu_hilo_if #(.WIDTH(32)) bus ();

  multu_hilo #(.WIDTH(32), .MULTU_CODE(MULTU)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference product from plain arithmetic.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Called at #1 after a rising edge with the block idle. Drives a MULTU for the
  // next edge (N) and checks every cycle through completion. With hammer set,
  // MULTU plus fresh operands are held on the bus for the whole busy window.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input bit hammer);
    bus.Signal = MULTU;
    bus.dataA  = a;
    bus.dataB  = b;
    @(posedge clk); #1;
    bus.Signal = 6'd0;
    bus.dataA  = $urandom;
    bus.dataB  = $urandom;
    for (int k = 0; k < 32; k++) begin
      chk("busy_during", {63'b0, bus.busy}, 64'd1);
      chk("done_during", {63'b0, bus.done}, 64'd0);
      chk("hi_hold", {32'b0, bus.HiOut}, {32'b0, model_hi});
      chk("lo_hold", {32'b0, bus.LoOut}, {32'b0, model_lo});
      if (hammer) begin
        bus.Signal = MULTU;
        bus.dataA  = $urandom;
        bus.dataB  = $urandom;
      end
      @(posedge clk); #1;
    end
    bus.Signal = 6'd0;
    chk("done_pulse", {63'b0, bus.done}, 64'd1);
    chk("busy_end", {63'b0, bus.busy}, 64'd0);
    chk("hi_result", {32'b0, bus.HiOut}, {32'b0, eh});
    chk("lo_result", {32'b0, bus.LoOut}, {32'b0, el});
    model_hi = eh;
    model_lo = el;
    @(posedge clk); #1;
    chk("done_single", {63'b0, bus.done}, 64'd0);
    chk("busy_after", {63'b0, bus.busy}, 64'd0);
  endtask

  logic [31:0] ra;
  logic [31:0] rb;
  logic [63:0] rp;
  logic [5:0]  codes[3];

  initial begin
    checks   = 0;
    errors   = 0;
    model_hi = '0;
    model_lo = '0;
    codes[0] = MFHI;
    codes[1] = MFLO;
    codes[2] = ADD;

    tbl[0] = '{a: 32'd3,          b: 32'd5,          hi: 32'h0000_0000, lo: 32'h0000_000F};
    tbl[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  hi: 32'hFFFF_FFFE, lo: 32'h0000_0001};
    tbl[2] = '{a: 32'h0001_0000,  b: 32'h0001_0000,  hi: 32'h0000_0001, lo: 32'h0000_0000};
    tbl[3] = '{a: 32'h8000_0000,  b: 32'd2,          hi: 32'h0000_0001, lo: 32'h0000_0000};
    tbl[4] = '{a: 32'd0,          b: 32'hDEAD_BEEF,  hi: 32'h0000_0000, lo: 32'h0000_0000};
    tbl[5] = '{a: 32'h1234_5678,  b: 32'h9ABC_DEF0,  hi: 32'h0B00_EA4E, lo: 32'h242D_2080};

    // Reset state.
    reset      = 1'b0;
    bus.Signal = 6'd0;
    bus.dataA  = '0;
    bus.dataB  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", {32'b0, bus.HiOut}, 64'd0);
    chk("rst_lo", {32'b0, bus.LoOut}, 64'd0);
    chk("rst_busy", {63'b0, bus.busy}, 64'd0);
    chk("rst_done", {63'b0, bus.done}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed vectors; the last one leaves 0x12345678*0x9ABCDEF0 in Hi/Lo.
    for (int i = 0; i < 6; i++)
      run_mul(tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, 1'b0);

    // 7*0 while MULTU and new operands are hammered throughout busy.
    run_mul(32'd7, 32'd0, 32'd0, 32'd0, 1'b1);

    // Randomized operands, some with hammering, against the arithmetic model.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'hFFFF_FFFF;
      rp = ref_mul(ra, rb);
      run_mul(ra, rb, rp[63:32], rp[31:0], i[0]);
    end

    // Non-MULTU codes never touch Hi/Lo or start anything.
    for (int c = 0; c < 40; c++) begin
      bus.Signal = codes[$urandom_range(0, 2)];
      bus.dataA  = $urandom;
      bus.dataB  = $urandom;
      @(posedge clk); #1;
      chk("other_hi", {32'b0, bus.HiOut}, {32'b0, model_hi});
      chk("other_lo", {32'b0, bus.LoOut}, {32'b0, model_lo});
      chk("other_busy", {63'b0, bus.busy}, 64'd0);
      chk("other_done", {63'b0, bus.done}, 64'd0);
    end
    bus.Signal = 6'd0;

    // Asynchronous reset mid-multiply: nonzero Hi/Lo first so clearing is visible.
    run_mul(32'd5, 32'd7, 32'd0, 32'd35, 1'b0);
    bus.Signal = MULTU;
    bus.dataA  = 32'h0001_0000;
    bus.dataB  = 32'h0001_0000;
    @(posedge clk); #1;
    bus.Signal = 6'd0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_hi", {32'b0, bus.HiOut}, 64'd0);
    chk("arst_lo", {32'b0, bus.LoOut}, 64'd0);
    chk("arst_busy", {63'b0, bus.busy}, 64'd0);
    chk("arst_done", {63'b0, bus.done}, 64'd0);
    model_hi = '0;
    model_lo = '0;
    #3;
    reset = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 40; c++) begin
      chk("post_rst_done", {63'b0, bus.done}, 64'd0);
      chk("post_rst_hi", {32'b0, bus.HiOut}, 64'd0);
      chk("post_rst_lo", {32'b0, bus.LoOut}, 64'd0);
      @(posedge clk); #1;
    end
    run_mul(32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0);

    // MULTU held continuously: starts at N and N+33, commits after N+32 and N+65.
    bus.Signal = MULTU;
    bus.dataA  = 32'd2;
    bus.dataB  = 32'd3;
    for (int c = 0; c <= 67; c++) begin
      @(posedge clk); #1;
      chk("hold_done", {63'b0, bus.done}, {63'b0, (c == 32 || c == 65)});
      chk("hold_busy", {63'b0, bus.busy}, {63'b0, (c < 32) || (c >= 33 && c < 65)});
      if (c == 32 || c == 65) begin
        chk("hold_lo", {32'b0, bus.LoOut}, 64'd6);
        chk("hold_hi", {32'b0, bus.HiOut}, 64'd0);
      end
      if (c == 65) bus.Signal = 6'd0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
